// File: rtl/dmem_lsu_pkg.sv
// ============================================================================
// Module  : dmem_lsu_pkg
// Brief   : Shared funct3 codes, FSM state type and lane/extension helpers
//           for the dmem_lsu load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LD_HI  = 3'd1,
    S_ST_HI  = 3'd2,
    S_LD_FMT = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  function automatic logic [3:0] base_be(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   base_be = 4'b0001;
      2'b01:   base_be = 4'b0011;
      default: base_be = 4'b1111;
    endcase
  endfunction

  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    if (we) is_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else    is_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Only meaningful for legal codes: f3[1:0]==01 is a half, 10 is a word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    is_misaligned = ((f3[1:0] == 2'b01) && (off == 2'd3)) ||
                    ((f3[1:0] == 2'b10) && (off != 2'd0));
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_B:    load_extend = {{24{d[7]}}, d[7:0]};
      F3_H:    load_extend = {{16{d[15]}}, d[15:0]};
      F3_BU:   load_extend = {24'd0, d[7:0]};
      F3_HU:   load_extend = {16'd0, d[15:0]};
      default: load_extend = d;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_lsu_bram.sv
// ============================================================================
// Module  : dmem_bram
// Brief   : Four-lane byte-writable RAM, one write port, one synchronous
//           read port, DEPTH_WORDS x 32 bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_bram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_we,
  input  logic [3:0]                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
  input  logic [31:0]                    i_wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_raddr,
  output logic [31:0]                    o_rdata
);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] rd_q;

    always_ff @(posedge i_clk) begin
      if (i_we && i_be[g]) lane_mem[i_waddr] <= i_wdata[8*g +: 8];
      rd_q <= lane_mem[i_raddr];
    end

    assign o_rdata[8*g +: 8] = rd_q;
  end

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
// Module  : dmem_lsu
// Brief   : RV32I MEM-stage load/store unit with valid/ready request,
//           registered response and byte-lane steering over dmem_bram.
//           Macro DMEM_MISALIGN_SPLIT_EN enables two-beat misaligned access;
//           otherwise misaligned requests are rejected with o_err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rdata,
  output logic              o_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t           state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_off;
  logic             w_accept;
  logic             w_legal;
  logic             w_mis;
  logic [31:0]      w_st_lo;
  logic [3:0]       w_be_lo;
  logic [31:0]      w_ld_aligned;

  logic             w_ram_we;
  logic [3:0]       w_ram_be;
  logic [IDX_W-1:0] w_ram_waddr;
  logic [31:0]      w_ram_wdata;
  logic [IDX_W-1:0] w_ram_raddr;
  logic [31:0]      w_ram_rdata;

  assign w_idx       = i_addr[IDX_W+1:2];
  assign w_off       = i_addr[1:0];
  assign o_req_ready = (state_q == S_IDLE);
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_legal     = is_legal(i_we, i_funct3);
  assign w_mis       = is_misaligned(i_funct3, w_off);
  assign w_st_lo     = i_wdata << {w_off, 3'b000};
  assign w_be_lo     = base_be(i_funct3) << w_off;

  if (ADDR_W > IDX_W + 2) begin : g_addr_hi
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^i_addr[ADDR_W-1:IDX_W+2];
  end

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [IDX_W-1:0] widx_q;
  logic [31:0]      hi_data_q;
  logic [3:0]       hi_be_q;
  logic [31:0]      lo_q;
  logic             split_q;
  logic [31:0]      w_st_hi;
  logic [3:0]       w_be_hi;

  // Bits pushed past lane 3 by the low-beat shift become the next word's beat.
  assign w_st_hi = i_wdata >> (6'd32 - {1'b0, w_off, 3'b000});
  assign w_be_hi = base_be(i_funct3) >> (3'd4 - {1'b0, w_off});
  assign w_ld_aligned = split_q ? 32'({w_ram_rdata, lo_q} >> {off_q, 3'b000})
                                : 32'({32'd0, w_ram_rdata} >> {off_q, 3'b000});

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      widx_q    <= w_idx;
      hi_data_q <= w_st_hi;
      hi_be_q   <= w_be_hi;
      split_q   <= w_mis;
    end
    if (state_q == S_LD_HI) lo_q <= w_ram_rdata;
  end
`else
  assign w_ld_aligned = w_ram_rdata >> {off_q, 3'b000};
`endif

  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      f3_q  <= i_funct3;
      off_q <= w_off;
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    w_ram_we    = 1'b0;
    w_ram_be    = w_be_lo;
    w_ram_waddr = w_idx;
    w_ram_wdata = w_st_lo;
    w_ram_raddr = w_idx;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal) begin
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (w_mis) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
            if (i_we) begin
              w_ram_we = 1'b1;
              state_d  = S_ST_HI;
            end else begin
              state_d  = S_LD_HI;
            end
`else
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = 32'd0;
`endif
          end else if (i_we) begin
            w_ram_we = 1'b1;
            state_d  = S_RESP;
            err_d    = 1'b0;
            rdata_d  = 32'd0;
          end else begin
            state_d  = S_LD_FMT;
          end
        end
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      S_LD_HI: begin
        w_ram_raddr = widx_q + 1'b1;
        state_d     = S_LD_FMT;
      end
      S_ST_HI: begin
        w_ram_we    = 1'b1;
        w_ram_be    = hi_be_q;
        w_ram_waddr = widx_q + 1'b1;
        w_ram_wdata = hi_data_q;
        state_d     = S_RESP;
        err_d       = 1'b0;
        rdata_d     = 32'd0;
      end
`endif
      S_LD_FMT: begin
        rdata_d = load_extend(f3_q, w_ld_aligned);
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;

  // Reset blocks the write so a split store's pending high beat is dropped.
  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we & i_rst_n),
    .i_be    (w_ram_be),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
// Module  : tb_dmem_lsu
// Brief   : Directed table-driven bench for dmem_lsu (DEPTH_WORDS=8), with
//           expectations for both DMEM_MISALIGN_SPLIT_EN settings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_lsu #(
    .DEPTH_WORDS(8),
    .ADDR_W     (32)
  ) u_dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_we        (we),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_rsp_valid (rsp_valid),
    .o_rdata     (rdata),
    .o_err       (err)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] d, input logic [31:0] er,
                              input logic ee, input int el);
    vec_t v;
    v.we = w; v.f3 = f; v.addr = a; v.wdata = d;
    v.exp_rd = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic e, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1 lat++;
    end
    rd = rdata;
    e  = err;
  endtask

  // Launch a request, then assert reset right after the accept edge.
  task automatic reset_after_accept(input logic w, input logic [2:0] f,
                                    input logic [31:0] a, input logic [31:0] d,
                                    input string tag);
    int pulses = 0;
    @(negedge clk);
    req_valid = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check({tag, " busy_ready"}, {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (rsp_valid) pulses++;
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 if (rsp_valid) pulses++;
    check({tag, " rsp_pulses"}, pulses, 32'd0);
    check({tag, " ready_after"}, {31'd0, req_ready}, 32'd1);
    check({tag, " rdata_after"}, rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    rst_n = 1'b0; req_valid = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;

    vecs.push_back(mk(1, LW,  32'h10, 32'hDEADBEEF, 32'h0,        0, 1));
    vecs.push_back(mk(0, LW,  32'h10, 32'h0,        32'hDEADBEEF, 0, 2));
    vecs.push_back(mk(1, LB,  32'h13, 32'hABCDEF80, 32'h0,        0, 1));
    vecs.push_back(mk(0, LB,  32'h13, 32'h0,        32'hFFFFFF80, 0, 2));
    vecs.push_back(mk(0, LBU, 32'h13, 32'h0,        32'h00000080, 0, 2));
    vecs.push_back(mk(0, LW,  32'h10, 32'h0,        32'h80ADBEEF, 0, 2));
    vecs.push_back(mk(0, LH,  32'h10, 32'h0,        32'hFFFFBEEF, 0, 2));
    vecs.push_back(mk(0, LHU, 32'h11, 32'h0,        32'h0000ADBE, 0, 2));
    vecs.push_back(mk(0, LH,  32'h12, 32'h0,        32'hFFFF80AD, 0, 2));
    vecs.push_back(mk(0, LB,  32'h11, 32'h0,        32'hFFFFFFBE, 0, 2));
    vecs.push_back(mk(1, LH,  32'h16, 32'hFFFF1234, 32'h0,        0, 1));
    vecs.push_back(mk(0, LHU, 32'h16, 32'h0,        32'h00001234, 0, 2));
    vecs.push_back(mk(0, LH,  32'h16, 32'h0,        32'h00001234, 0, 2));
    vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0,     32'h0,        1, 1));
    vecs.push_back(mk(1, 3'b100, 32'h10, 32'h0,     32'h0,        1, 1));
    vecs.push_back(mk(1, 3'b011, 32'h10, 32'h0,     32'h0,        1, 1));
    vecs.push_back(mk(0, 3'b111, 32'h10, 32'h0,     32'h0,        1, 1));
    vecs.push_back(mk(0, LW,  32'h10, 32'h0,        32'h80ADBEEF, 0, 2));
    vecs.push_back(mk(0, LW,  32'h30, 32'h0,        32'h80ADBEEF, 0, 2));
    // Misaligned paths: split gives a result, otherwise rejected with no write.
    vecs.push_back(mk(1, LW,  32'h0E, 32'h11223344, 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vecs.push_back(mk(0, LW,  32'h0E, 32'h0, SPLIT ? 32'h11223344 : 32'h0, !SPLIT, SPLIT ? 3 : 1));
    vecs.push_back(mk(0, LHU, 32'h0F, 32'h0, SPLIT ? 32'h00002233 : 32'h0, !SPLIT, SPLIT ? 3 : 1));
    vecs.push_back(mk(0, LW,  32'h10, 32'h0, SPLIT ? 32'h80AD1122 : 32'h80ADBEEF, 0, 2));
    vecs.push_back(mk(1, LH,  32'h13, 32'h00005566, 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vecs.push_back(mk(0, LW,  32'h10, 32'h0, SPLIT ? 32'h66AD1122 : 32'h80ADBEEF, 0, 2));
    vecs.push_back(mk(1, LW,  32'h00, 32'h01020304, 32'h0,        0, 1));
    vecs.push_back(mk(1, LW,  32'h1D, 32'hAABBCCDD, 32'h0, !SPLIT, SPLIT ? 2 : 1));
    vecs.push_back(mk(0, LW,  32'h1D, 32'h0, SPLIT ? 32'hAABBCCDD : 32'h0, !SPLIT, SPLIT ? 3 : 1));
    vecs.push_back(mk(0, LBU, 32'h00, 32'h0, SPLIT ? 32'h000000AA : 32'h00000004, 0, 2));
    vecs.push_back(mk(0, LW,  32'h00, 32'h0, SPLIT ? 32'h010203AA : 32'h01020304, 0, 2));
    vecs.push_back(mk(0, LHU, 32'h1F, 32'h0, SPLIT ? 32'h0000AABB : 32'h0, !SPLIT, SPLIT ? 3 : 1));
    vecs.push_back(mk(1, LW,  32'h04, 32'h0A0B0C0D, 32'h0,        0, 1));
    vecs.push_back(mk(0, LW,  32'h02, 32'h0, SPLIT ? 32'h0C0D0102 : 32'h0, !SPLIT, SPLIT ? 3 : 1));

    repeat (3) @(posedge clk);
    #1;
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset err",       {31'd0, err},       32'd0);
    check("reset rdata",     rdata,              32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset ready", {31'd0, req_ready}, 32'd1);

    foreach (vecs[i]) begin
      do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, e, lat);
      check($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
      @(posedge clk);
      #1 check($sformatf("v%0d pulse_end", i), {31'd0, rsp_valid}, 32'd0);
    end

    // Reset during an aligned load: no response, outputs cleared.
    reset_after_accept(1'b0, LW, 32'h10, 32'h0, "rst_ld");

`ifdef DMEM_MISALIGN_SPLIT_EN
    do_req(1'b1, LW, 32'h04, 32'h0, rd, e, lat);
    do_req(1'b1, LW, 32'h08, 32'h0, rd, e, lat);
    do_req(1'b0, LW, 32'h04, 32'h0, rd, e, lat);
    reset_after_accept(1'b1, LW, 32'h06, 32'h55667788, "rst_st_hi");
    do_req(1'b0, LW, 32'h04, 32'h0, rd, e, lat);
    check("rst_st_hi low_beat", rd, 32'h77880000);
    do_req(1'b0, LW, 32'h08, 32'h0, rd, e, lat);
    check("rst_st_hi high_beat", rd, 32'h00000000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
